// File: rtl/replacing_tag_directory.sv
// Purpose: fully associative tag directory with exact recency order, victim selection and explicit eviction.
// Latency: lookup and allocation choice are combinational from registered state; updates land on the next clock edge.
// Backpressure: none; allocate, search and evict are accepted every cycle. Optional macro REPLACING_TAG_DIRECTORY_SEARCH_TOUCH_EN makes search hits refresh recency (LRU instead of FIFO).
module replacing_tag_directory #(
  parameter  int WIDTH       = 8,
  parameter  int DEPTH       = 16,
  localparam int INDEX_WIDTH = $clog2(DEPTH),
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   full,
  output logic                   empty,
  output logic [COUNT_WIDTH-1:0] count,
  input  logic                   allocate_enable,
  input  logic [WIDTH-1:0]       allocate_tag,
  output logic [INDEX_WIDTH-1:0] allocate_index,
  output logic                   allocate_victim_valid,
  output logic [WIDTH-1:0]       allocate_victim_tag,
  input  logic                   search_enable,
  input  logic [WIDTH-1:0]       search_tag,
  output logic                   search_hit,
  output logic [INDEX_WIDTH-1:0] search_index,
  input  logic                   evict_enable,
  input  logic [INDEX_WIDTH-1:0] evict_index
);

  // Registered directory state; age 0 is the most recently written or touched entry.
  logic [DEPTH-1:0]       valid_q;
  logic [WIDTH-1:0]       tag_q [DEPTH];
  logic [INDEX_WIDTH-1:0] age_q [DEPTH];

  logic [DEPTH-1:0]       valid_d;
  logic [WIDTH-1:0]       tag_d [DEPTH];
  logic [INDEX_WIDTH-1:0] age_d [DEPTH];

  logic                   dup_found;
  logic [INDEX_WIDTH-1:0] dup_index;
  logic                   free_found;
  logic [INDEX_WIDTH-1:0] free_index;
  logic                   oldest_found;
  logic [INDEX_WIDTH-1:0] oldest_index;
  logic [INDEX_WIDTH-1:0] oldest_age;

  logic                   evict_hit;
  logic                   touch_hit;
  logic [INDEX_WIDTH-1:0] touch_age;
  logic                   alloc_was_valid;
  logic [INDEX_WIDTH-1:0] alloc_age;

  // Occupancy flags and population count of the valid vector.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        count = count + COUNT_WIDTH'(1);
      end
    end
    full  = &valid_q;
    empty = ~|valid_q;
  end

  // Lookup: descending scan so the lowest matching index wins.
  always_comb begin
    search_hit   = 1'b0;
    search_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (search_enable && valid_q[i] && (tag_q[i] == search_tag)) begin
        search_hit   = 1'b1;
        search_index = INDEX_WIDTH'(i);
      end
    end
  end

  // Candidate entries for allocation: existing copy of the tag, lowest free slot, oldest valid entry.
  always_comb begin
    dup_found    = 1'b0;
    dup_index    = '0;
    free_found   = 1'b0;
    free_index   = '0;
    oldest_found = 1'b0;
    oldest_index = '0;
    oldest_age   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == allocate_tag)) begin
        dup_found = 1'b1;
        dup_index = INDEX_WIDTH'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_index = INDEX_WIDTH'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (!oldest_found || (age_q[i] > oldest_age))) begin
        oldest_found = 1'b1;
        oldest_index = INDEX_WIDTH'(i);
        oldest_age   = age_q[i];
      end
    end
  end

  // Allocation priority: reuse a duplicate, then fill a hole, and only then displace the oldest entry.
  always_comb begin
    allocate_index        = '0;
    allocate_victim_valid = 1'b0;
    allocate_victim_tag   = '0;
    if (dup_found) begin
      allocate_index = dup_index;
    end else if (free_found) begin
      allocate_index = free_index;
    end else begin
      allocate_index        = oldest_index;
      allocate_victim_valid = 1'b1;
      allocate_victim_tag   = tag_q[oldest_index];
    end
  end

  // Next state applied in order evict -> touch -> allocate so the allocated entry always ends youngest.
  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    age_d           = age_q;
    touch_hit       = 1'b0;
    touch_age       = '0;
    alloc_was_valid = 1'b0;
    alloc_age       = '0;

    // An allocation landing on the evicted slot overrides the eviction.
    evict_hit = evict_enable && valid_q[evict_index] &&
                !(allocate_enable && (allocate_index == evict_index));
    if (evict_hit) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_q[j] && (age_q[j] > age_q[evict_index])) begin
          age_d[j] = age_q[j] - INDEX_WIDTH'(1);
        end
      end
      valid_d[evict_index] = 1'b0;
      age_d[evict_index]   = '0;
    end

`ifdef REPLACING_TAG_DIRECTORY_SEARCH_TOUCH_EN
    touch_hit = search_hit && valid_d[search_index] &&
                !(allocate_enable && (allocate_index == search_index));
`endif
    if (touch_hit) begin
      touch_age = age_d[search_index];
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_d[j] && (age_d[j] < touch_age)) begin
          age_d[j] = age_d[j] + INDEX_WIDTH'(1);
        end
      end
      age_d[search_index] = '0;
    end

    if (allocate_enable) begin
      alloc_was_valid = valid_d[allocate_index];
      alloc_age       = age_d[allocate_index];
      for (int j = 0; j < DEPTH; j++) begin
        if ((INDEX_WIDTH'(j) != allocate_index) && valid_d[j] &&
            (!alloc_was_valid || (age_d[j] < alloc_age))) begin
          age_d[j] = age_d[j] + INDEX_WIDTH'(1);
        end
      end
      valid_d[allocate_index] = 1'b1;
      tag_d[allocate_index]   = allocate_tag;
      age_d[allocate_index]   = '0;
    end
  end

  // State register; reset overrides every same-cycle request.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_replacing_tag_directory.sv
// Directed scoreboard bench for replacing_tag_directory at WIDTH=8, DEPTH=4.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
// Expected victims depend on REPLACING_TAG_DIRECTORY_SEARCH_TOUCH_EN (LRU vs FIFO).
module tb_replacing_tag_directory;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int IW    = 2;
  localparam int CW    = 3;

  localparam int M_F  = 1;
  localparam int M_E  = 2;
  localparam int M_C  = 4;
  localparam int M_AI = 8;
  localparam int M_VV = 16;
  localparam int M_VT = 32;
  localparam int M_H  = 64;
  localparam int M_SI = 128;

`ifdef REPLACING_TAG_DIRECTORY_SEARCH_TOUCH_EN
  localparam int V7_IDX = 2;
  localparam int V7_TAG = 8'h33;
  localparam int V9_IDX = 0;
  localparam int V9_TAG = 8'h55;
  localparam int T_E1   = 8'h22;
  localparam int T_E2   = 8'h66;
`else
  localparam int V7_IDX = 1;
  localparam int V7_TAG = 8'h22;
  localparam int V9_IDX = 2;
  localparam int V9_TAG = 8'h33;
  localparam int T_E1   = 8'h66;
  localparam int T_E2   = 8'h33;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic             allocate_enable;
  logic [WIDTH-1:0] allocate_tag;
  logic [IW-1:0]    allocate_index;
  logic             allocate_victim_valid;
  logic [WIDTH-1:0] allocate_victim_tag;
  logic             search_enable;
  logic [WIDTH-1:0] search_tag;
  logic             search_hit;
  logic [IW-1:0]    search_index;
  logic             evict_enable;
  logic [IW-1:0]    evict_index;

  always #5 clock = ~clock;

  replacing_tag_directory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .full                  (full),
    .empty                 (empty),
    .count                 (count),
    .allocate_enable       (allocate_enable),
    .allocate_tag          (allocate_tag),
    .allocate_index        (allocate_index),
    .allocate_victim_valid (allocate_victim_valid),
    .allocate_victim_tag   (allocate_victim_tag),
    .search_enable         (search_enable),
    .search_tag            (search_tag),
    .search_hit            (search_hit),
    .search_index          (search_index),
    .evict_enable          (evict_enable),
    .evict_index           (evict_index)
  );

  typedef struct packed {
    logic [7:0]       step;
    logic [7:0]       mask;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [IW-1:0]    aidx;
    logic             vv;
    logic [WIDTH-1:0] vtag;
    logic             hit;
    logic [IW-1:0]    sidx;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  task automatic cmp(input int step, input string what, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL step%0d %s: got 0x%0h, expected 0x%0h", step, what, act, req);
    end
  endtask

  // Monitor: one expectation per strobed cycle, sampled on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (chk_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output strobed with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if ((e.mask & M_F)  != 0) cmp(e.step, "full",       full,                  e.full);
        if ((e.mask & M_E)  != 0) cmp(e.step, "empty",      empty,                 e.empty);
        if ((e.mask & M_C)  != 0) cmp(e.step, "count",      count,                 e.count);
        if ((e.mask & M_AI) != 0) cmp(e.step, "alloc_idx",  allocate_index,        e.aidx);
        if ((e.mask & M_VV) != 0) cmp(e.step, "victim_vld", allocate_victim_valid, e.vv);
        if ((e.mask & M_VT) != 0) cmp(e.step, "victim_tag", allocate_victim_tag,   e.vtag);
        if ((e.mask & M_H)  != 0) cmp(e.step, "search_hit", search_hit,            e.hit);
        if ((e.mask & M_SI) != 0) cmp(e.step, "search_idx", search_index,          e.sidx);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic drive(input int rst, input int ae, input int atag, input int se,
                       input int stag, input int ee, input int eidx);
    @(posedge clock);
    #1;
    chk_vld         = 1'b0;
    reset           = rst[0];
    allocate_enable = ae[0];
    allocate_tag    = WIDTH'(atag);
    search_enable   = se[0];
    search_tag      = WIDTH'(stag);
    evict_enable    = ee[0];
    evict_index     = IW'(eidx);
  endtask

  task automatic push_exp(input int step, input int mask, input int f, input int em,
                          input int c, input int ai, input int vv, input int vt,
                          input int h, input int si);
    exp_t e;
    e.step  = 8'(step);
    e.mask  = 8'(mask);
    e.full  = f[0];
    e.empty = em[0];
    e.count = CW'(c);
    e.aidx  = IW'(ai);
    e.vv    = vv[0];
    e.vtag  = WIDTH'(vt);
    e.hit   = h[0];
    e.sidx  = IW'(si);
    exp_q.push_back(e);
    chk_vld = 1'b1;
  endtask

  localparam int ALL = 255;

  initial begin
    reset = 1'b1; allocate_enable = 1'b0; allocate_tag = '0; search_enable = 1'b0;
    search_tag = '0; evict_enable = 1'b0; evict_index = '0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);

    // Reset state with a search of 0x00.
    drive(0, 0, 0, 1, 8'h00, 0, 0);
    push_exp(0, ALL, 0, 1, 0, 0, 0, 0, 0, 0);

    // Fill.
    drive(0, 1, 8'h11, 0, 0, 0, 0); push_exp(1, M_AI|M_VV|M_C|M_E, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 8'h22, 0, 0, 0, 0); push_exp(2, M_AI|M_VV|M_C|M_E, 0, 0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 8'h33, 0, 0, 0, 0); push_exp(3, M_AI|M_VV|M_C,     0, 0, 2, 2, 0, 0, 0, 0);
    drive(0, 1, 8'h44, 0, 0, 0, 0); push_exp(4, M_AI|M_VV|M_C|M_F, 0, 0, 3, 3, 0, 0, 0, 0);

    // Replace oldest (0x11 at index 0).
    drive(0, 1, 8'h55, 0, 0, 0, 0);
    push_exp(5, M_F|M_E|M_C|M_AI|M_VV|M_VT, 1, 0, 4, 0, 1, 8'h11, 0, 0);

    // Search 0x22, then allocate 0x66: victim depends on touch.
    drive(0, 0, 0, 1, 8'h22, 0, 0); push_exp(6, M_H|M_SI|M_C, 0, 0, 4, 0, 0, 0, 1, 1);
    drive(0, 1, 8'h66, 0, 0, 0, 0);
    push_exp(7, M_C|M_AI|M_VV|M_VT, 0, 0, 4, V7_IDX, 1, V7_TAG, 0, 0);

    // Duplicate allocate while full.
    drive(0, 1, 8'h44, 0, 0, 0, 0); push_exp(8, M_C|M_AI|M_VV|M_VT, 0, 0, 4, 3, 0, 0, 0, 0);
    drive(0, 0, 8'h99, 1, 8'h44, 0, 0);
    push_exp(9, M_F|M_C|M_H|M_SI|M_AI|M_VV|M_VT, 1, 0, 4, V9_IDX, 1, V9_TAG, 1, 3);

    // Steer oldest to index 2 in both builds.
    drive(0, 0, 0, 1, 8'h55, 0, 0); push_exp(10, M_H|M_SI, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, T_E1, 0, 0);  push_exp(11, M_H|M_SI, 0, 0, 0, 0, 0, 0, 1, 1);

    // Collision: evict 2 and allocate 0x77 to 2; allocate wins.
    drive(0, 1, 8'h77, 0, 0, 1, 2);
    push_exp(12, M_C|M_AI|M_VV|M_VT, 0, 0, 4, 2, 1, T_E2, 0, 0);
    drive(0, 0, 0, 1, 8'h77, 0, 0); push_exp(13, M_F|M_C|M_H|M_SI, 1, 0, 4, 0, 0, 0, 1, 2);

    // Evict index 0, then evict it again while invalid.
    drive(0, 0, 0, 0, 0, 1, 0);     push_exp(14, M_C, 0, 0, 4, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 8'h55, 1, 0);
    push_exp(15, M_F|M_C|M_H|M_SI|M_AI|M_VV, 0, 0, 3, 0, 0, 0, 0, 0);

    // Allocate into hole and evict a different entry in one cycle.
    drive(0, 1, 8'h99, 0, 0, 1, 3); push_exp(16, M_C|M_AI|M_VV|M_VT, 0, 0, 3, 0, 0, 0, 0, 0);
    drive(0, 0, 8'h99, 1, 8'h44, 0, 0);
    push_exp(17, M_C|M_H|M_SI|M_AI|M_VV, 0, 0, 3, 0, 0, 0, 0, 0);
    drive(0, 0, 8'hAA, 1, 8'h99, 0, 0);
    push_exp(18, M_F|M_E|M_C|M_H|M_SI|M_AI|M_VV, 0, 0, 3, 3, 0, 0, 1, 0);

    // Reset alongside allocate and evict.
    drive(1, 1, 8'hBB, 1, 8'h77, 1, 1);
    drive(0, 0, 8'hBB, 1, 8'h99, 0, 0); push_exp(20, ALL, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 8'h77, 0, 0);     push_exp(21, M_H|M_SI|M_C|M_E, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 8'hBB, 0, 0);     push_exp(22, M_H|M_SI|M_E, 0, 1, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
